data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter TAG_BITS, 3, width of the stored tag (address[7:5]).
REQ-002 Parameter INDEX_BITS, 3, line index width (address[4:2]); the cache SHALL hold 8 lines.
REQ-003 Parameter BLOCK_BYTES, 4, bytes per line (address[1:0] byte offset).
REQ-004 Ports SHALL be, in this order:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  CPU load request, level, held until busywait low.
- write  input  1  CPU store request, level, held until busywait low.
- address  input  8  CPU byte address {tag[7:5], index[4:2], offset[1:0]}.
- writedata  input  8  store byte.
- readdata  output  8  load byte.
- busywait  output  1  CPU stall.
- mem_read  output  1  block read request to data memory.
- mem_write  output  1  block write request to data memory.
- mem_address  output  6  block address {tag, index}.
- mem_writedata  output  32  evicted block; byte n in bits [8n+7:8n].
- mem_readdata  input  32  fetched block, same byte order.
- mem_busywait  input  1  memory stall; transfer complete on the first clk edge where it is low.
REQ-005 Clock and reset SHALL be one clock and a synchronous, active-high reset, named clk and reset.

Function
REQ-006 Storage SHALL be 8 lines, each with a 32-bit data block, 3-bit tag, valid bit and dirty bit.
REQ-007 Hit SHALL be valid[index] AND (tag[index] == address[7:5]), evaluated combinationally.
REQ-008 FSM states SHALL be IDLE, WRITE_BACK, MEM_READ and UPDATE.
REQ-009 In IDLE, busywait SHALL be 1 when (read|write) and not hit, and 0 otherwise.
REQ-010 In WRITE_BACK, MEM_READ and UPDATE, busywait SHALL be 1.
REQ-011 Read hit: readdata SHALL equal the addressed byte combinationally in the same cycle, with zero stall cycles.
REQ-012 Write hit: at the next rising edge the addressed byte SHALL take writedata and dirty SHALL be set; other bytes are unchanged.
REQ-013 Miss in IDLE SHALL go to WRITE_BACK if valid&dirty, otherwise to MEM_READ.
REQ-014 WRITE_BACK SHALL drive mem_write=1, mem_address={stored tag, index} and mem_writedata=the stored block.
REQ-015 WRITE_BACK SHALL go to MEM_READ on the first edge with mem_busywait=0.
REQ-016 MEM_READ SHALL drive mem_read=1 and mem_address={address[7:5], index}.
REQ-017 MEM_READ SHALL go to UPDATE on the first edge with mem_busywait=0.
REQ-018 UPDATE SHALL, in exactly one cycle, load mem_readdata into the line, set the tag to address[7:5], set valid=1 and dirty=0, then go to IDLE.
REQ-019 After UPDATE, the held request SHALL be served as a hit in IDLE, including a store (write-allocate).
REQ-020 mem_read and mem_write SHALL never both be 1, and SHALL both be 0 in IDLE and UPDATE.
REQ-021 If read and write are both 1, the access SHALL be treated as a write; readdata is then don't-care.
REQ-022 With read=write=0, the FSM SHALL stay in IDLE, busywait=0, and no line SHALL change.
REQ-023 Address, read and write changing while busywait=1 is illegal; the cache is not required to handle it.
REQ-024 Outputs SHALL be glitch-stable between edges except readdata and busywait, which are combinational.
REQ-025 Total miss latency SHALL be (write-back cycles if dirty) + (fetch cycles) + 1 UPDATE cycle + 1 hit cycle.

Reset
REQ-026 On reset=1 at a rising edge, all valid and dirty bits SHALL clear, and the FSM SHALL go to IDLE.
REQ-027 After reset, mem_read, mem_write and busywait SHALL be 0, readdata=0 and mem_address=0.
REQ-028 Reset mid-WRITE_BACK or mid-MEM_READ SHALL abort the transfer and drop mem_read/mem_write after that edge.
REQ-029 Dirty data lost to a reset SHALL NOT be flushed to memory.
REQ-030 Data arrays need not be cleared by reset.

Verification
REQ-031 Reset, then read address 0x00, memory block 0x44332211, 5-cycle memory -> busywait high, one MEM_READ burst at mem_address 0x00, UPDATE, then readdata=0x11 and busywait low.
REQ-032 Read 0x03 right after REQ-031 -> hit, busywait stays 0, readdata=0x44.
REQ-033 Write 0xAB to 0x01 (hit) -> next read 0x01 returns 0xAB; line 0 dirty; no memory traffic.
REQ-034 Read 0x20 (same index 0, tag 1) -> WRITE_BACK with mem_address 0x00, mem_writedata 0x4433AB11, then MEM_READ at mem_address 0x08.
REQ-035 Assert reset during MEM_READ -> after that edge mem_read=0, busywait=0, and a read of 0x00 misses again.
REQ-036 Write 0x5A to 0xFC (index 7, tag 7) after reset -> no WRITE_BACK; MEM_READ at 0x3F, then byte 0 of the line is 0x5A and dirty=1.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// There are 8 lines of 4 bytes each. The byte address is split as
// {tag[7:5], index[4:2], offset[1:0]}.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   read, write     CPU load/store request (level, held while busywait=1)
//   address         CPU byte address
//   writedata       store byte
//   readdata        load byte (combinational on a hit)
//   busywait        CPU stall (combinational)
//   mem_read        registered block fetch request
//   mem_write       registered block write-back request
//   mem_address     registered block address {tag, index}
//   mem_writedata   registered evicted block, byte n in bits [8n+7:8n]
//   mem_readdata    fetched block, same byte order
//   mem_busywait    memory stall; a transfer completes on the first edge where it is low
module data_cache #(
  parameter int unsigned TAG_BITS    = 3,
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned BLOCK_BYTES = 4
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               read,
  input  logic                                               write,
  input  logic [TAG_BITS+INDEX_BITS+$clog2(BLOCK_BYTES)-1:0] address,
  input  logic [7:0]                                         writedata,
  output logic [7:0]                                         readdata,
  output logic                                               busywait,
  output logic                                               mem_read,
  output logic                                               mem_write,
  output logic [TAG_BITS+INDEX_BITS-1:0]                     mem_address,
  output logic [8*BLOCK_BYTES-1:0]                           mem_writedata,
  input  logic [8*BLOCK_BYTES-1:0]                           mem_readdata,
  input  logic                                               mem_busywait
);

  localparam int unsigned OFF_BITS = $clog2(BLOCK_BYTES);
  localparam int unsigned ADDR_W   = TAG_BITS + INDEX_BITS + OFF_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned BLOCK_W  = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

  state_t                state;
  logic [BLOCK_W-1:0]    data_q [LINES];
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;

  logic [TAG_BITS-1:0]   tag_f;
  logic [INDEX_BITS-1:0] idx;
  logic [OFF_BITS-1:0]   off;
  logic                  hit;
  logic                  access;

  assign tag_f  = address[ADDR_W-1 -: TAG_BITS];
  assign idx    = address[OFF_BITS +: INDEX_BITS];
  assign off    = address[OFF_BITS-1:0];
  assign access = read | write;
  assign hit    = valid_q[idx] && (tag_q[idx] == tag_f);

  always_comb begin
    busywait = (state != IDLE) || (access && !hit);
    readdata = '0;
    if (state == IDLE && hit && read && !write)
      readdata = data_q[idx][{off, 3'b000} +: 8];
  end

  // The data array is not reset. A line's contents only matter while its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == UPDATE)
      data_q[idx] <= mem_readdata;
    else if (state == IDLE && write && hit)
      data_q[idx][{off, 3'b000} +: 8] <= writedata;
  end

  // The memory-side outputs are registered. Each transfer therefore begins on
  // the edge that follows miss detection. A write-back hands off directly to
  // the fetch without dropping the request for a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid_q       <= '0;
      dirty_q       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (write && hit) begin
            dirty_q[idx] <= 1'b1;
          end else if (access && !hit) begin
            if (valid_q[idx] && dirty_q[idx]) begin
              state         <= WRITE_BACK;
              mem_write     <= 1'b1;
              mem_address   <= {tag_q[idx], idx};
              mem_writedata <= data_q[idx];
            end else begin
              state       <= MEM_READ;
              mem_read    <= 1'b1;
              mem_address <= {tag_f, idx};
            end
          end
        end
        WRITE_BACK: begin
          if (!mem_busywait) begin
            state       <= MEM_READ;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
            mem_address <= {tag_f, idx};
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            state    <= UPDATE;
            mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          tag_q[idx]   <= tag_f;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache.
// A behavioural block memory with a fixed latency sits on the memory side.
// Load results are predicted from a flat byte-image of what the CPU should
// observe. Memory transfers are predicted per scenario and checked as they complete.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  data_cache #(.TAG_BITS(3), .INDEX_BITS(3), .BLOCK_BYTES(4)) dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] blk_init(input int unsigned b);
    logic [7:0] lo;
    lo = 8'(b);
    if (b == 0) return 32'h44332211;
    return 32'hA0B0C0D0 ^ {4{lo}};
  endfunction

  // ---------------- memory model ----------------
  localparam int unsigned MEM_LAT = 5;  // cycles with mem_busywait high per transfer
  logic [31:0]  mem [64];
  logic         mem_load;
  int unsigned  lat_cnt;

  assign mem_busywait = (mem_read | mem_write) && (lat_cnt != MEM_LAT);
  assign mem_readdata = mem[mem_address];

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } tx_t;

  tx_t  tx_q[$];
  logic tx_check_en;

  always @(posedge clk) begin : mem_model
    tx_t e;
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= blk_init(i);
      lat_cnt <= 0;
    end else if ((mem_read | mem_write) && !mem_busywait) begin
      lat_cnt <= 0;
      if (mem_write) mem[mem_address] <= mem_writedata;
      check("mem_excl", 32'(mem_read & mem_write), 32'd0);
      if (tx_check_en) begin
        check("tx_expected", 32'(tx_q.size() > 0), 32'd1);
        if (tx_q.size() > 0) begin
          e = tx_q.pop_front();
          check("tx_kind", 32'(mem_write), 32'(e.wr));
          check("tx_addr", 32'(mem_address), 32'(e.addr));
          if (e.wr) check("tx_wdata", mem_writedata, e.data);
        end
      end
    end else if (mem_read | mem_write) begin
      lat_cnt <= lat_cnt + 1;
    end else begin
      lat_cnt <= 0;
    end
  end

  // ---------------- CPU-side model and stimulus ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] rd_q[$];

  task automatic expect_tx(input logic wr, input logic [5:0] a, input logic [31:0] d);
    tx_q.push_back(tx_t'{wr: wr, addr: a, data: d});
  endtask

  // Hold one request until busywait drops. Return the number of stall cycles.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output int cyc);
    if (rd && !wr) rd_q.push_back(ref_mem[a]);
    @(negedge clk);
    read = rd; write = wr; address = a; writedata = wd;
    #1;
    cyc = 0;
    while (busywait && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("stall_bound", 32'(busywait), 32'd0);
    if (rd && !wr) check("readdata", 32'(readdata), 32'(rd_q.pop_front()));
    if (wr) ref_mem[a] = wd;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      check("idle_busy", 32'(busywait), 32'd0);
      check("idle_mem", 32'({mem_read, mem_write}), 32'd0);
    end
  endtask

  // Stall cycles include the miss-detection cycle, each transfer
  // (MEM_LAT busy + 1 completing cycle), and the UPDATE cycle.
  localparam int CLEAN_MISS = MEM_LAT + 3;
  localparam int DIRTY_MISS = 2 * MEM_LAT + 4;

  initial begin
    int          cyc;
    logic [31:0] w;
    logic [31:0] wb;
    logic [7:0]  a;
    int          op;

    for (int i = 0; i < 256; i++) begin
      w = blk_init(i / 4);
      ref_mem[i] = w[8*(i%4) +: 8];
    end
    mem_load = 1'b1; reset = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; tx_check_en = 1'b1;
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    #1;
    check("rst_busy", 32'(busywait), 32'd0);
    check("rst_mr", 32'(mem_read), 32'd0);
    check("rst_mw", 32'(mem_write), 32'd0);
    check("rst_rdata", 32'(readdata), 32'd0);
    check("rst_maddr", 32'(mem_address), 32'd0);
    reset = 1'b0;

    // Cold read miss, then hit on the same line.
    expect_tx(1'b0, 6'h00, '0);
    access(1'b1, 1'b0, 8'h00, 8'h00, cyc);
    check("cold_lat", 32'(cyc), 32'(CLEAN_MISS));
    access(1'b1, 1'b0, 8'h03, 8'h00, cyc);
    check("hit_lat", 32'(cyc), 32'd0);

    // Write hit, then read it back without any memory traffic.
    access(1'b0, 1'b1, 8'h01, 8'hAB, cyc);
    check("whit_lat", 32'(cyc), 32'd0);
    access(1'b1, 1'b0, 8'h01, 8'h00, cyc);
    check("rhit_lat", 32'(cyc), 32'd0);

    // Conflict on index 0 with a dirty line: write-back, then fetch.
    expect_tx(1'b1, 6'h00, 32'h4433AB11);
    expect_tx(1'b0, 6'h08, '0);
    access(1'b1, 1'b0, 8'h20, 8'h00, cyc);
    check("dirty_lat", 32'(cyc), 32'(DIRTY_MISS));

    // The line is clean now, so there is no write-back. The data must come back from memory.
    expect_tx(1'b0, 6'h00, '0);
    access(1'b1, 1'b0, 8'h01, 8'h00, cyc);
    check("refetch_lat", 32'(cyc), 32'(CLEAN_MISS));

    // Make line 0 dirty, then abort a fetch on index 1 with a reset.
    access(1'b0, 1'b1, 8'h00, 8'h77, cyc);
    @(negedge clk);
    read = 1'b1; write = 1'b0; address = 8'h44;
    repeat (2) @(negedge clk);
    #1;
    check("mr_active", 32'(mem_read), 32'd1);
    check("mr_addr", 32'(mem_address), 32'h11);
    @(negedge clk);
    reset = 1'b1; read = 1'b0;
    @(negedge clk); #1;
    check("abort_mr", 32'(mem_read), 32'd0);
    check("abort_mw", 32'(mem_write), 32'd0);
    check("abort_busy", 32'(busywait), 32'd0);
    reset = 1'b0;
    // The dirty 0x77 is discarded. Memory still holds the earlier written-back byte 0x11.
    ref_mem[8'h00] = 8'h11;
    expect_tx(1'b0, 6'h00, '0);
    access(1'b1, 1'b0, 8'h00, 8'h00, cyc);
    check("post_rst_lat", 32'(cyc), 32'(CLEAN_MISS));

    // A write miss allocates the line without a write-back.
    expect_tx(1'b0, 6'h3F, '0);
    access(1'b0, 1'b1, 8'hFC, 8'h5A, cyc);
    check("wmiss_lat", 32'(cyc), 32'(CLEAN_MISS));
    access(1'b1, 1'b0, 8'hFC, 8'h00, cyc);
    check("walloc_hit", 32'(cyc), 32'd0);
    wb = {ref_mem[8'hFF], ref_mem[8'hFE], ref_mem[8'hFD], ref_mem[8'hFC]};
    expect_tx(1'b1, 6'h3F, wb);
    expect_tx(1'b0, 6'h07, '0);
    access(1'b1, 1'b0, 8'h1C, 8'h00, cyc);
    check("evict7_lat", 32'(cyc), 32'(DIRTY_MISS));

    // With read and write both asserted, the request behaves as a store.
    access(1'b1, 1'b1, 8'h1D, 8'h99, cyc);
    check("rw_lat", 32'(cyc), 32'd0);
    access(1'b1, 1'b0, 8'h1D, 8'h00, cyc);

    idle_cycles(3);
    check("tx_left", 32'(tx_q.size()), 32'd0);

    // Random mix over a small address window to force conflicts and evictions.
    tx_check_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      a  = 8'($urandom) & 8'h6F;
      op = int'($urandom_range(0, 4));
      if (op < 2)       access(1'b1, 1'b0, a, 8'h00, cyc);
      else if (op < 4)  access(1'b0, 1'b1, a, 8'($urandom), cyc);
      else              access(1'b1, 1'b1, a, 8'($urandom), cyc);
    end
    idle_cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
